dpll_phase_ctrl: RTL and testbench

Clock-recovery phase controller for the receiver's digital PLL. Takes the raw ahead/behind pulses from the phase detector, re-times them into the high-speed clock domain, and filters them with a programmable random-walk counter. It then schedules at most one phase correction per recovered-clock period on an internal divide-by-N counter that generates the recovered clock. It also reports lock status.

---
 rtl/dpll_phase_ctrl_if.sv | 14 +
 rtl/dpll_phase_ctrl.sv | 119 +++++++++++
 tb/tb_dpll_phase_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dpll_phase_ctrl_if.sv
// dpll_phase_ctrl_if: phase-detector inputs, filter threshold and correction/lock status of the DPLL phase controller
interface dpll_phase_ctrl_if;
  logic       ahead_in;
  logic       behind_in;
  logic [3:0] k_sel;
  logic       rec_clk;
  logic       adj_adv;
  logic       adj_ret;
  logic       busy;
  logic       locked;
  logic       ovf;
  modport master(output ahead_in, behind_in, k_sel, input rec_clk, adj_adv, adj_ret, busy, locked, ovf);
  modport slave(input ahead_in, behind_in, k_sel, output rec_clk, adj_adv, adj_ret, busy, locked, ovf);
endinterface

// File: rtl/dpll_phase_ctrl.sv
// dpll_phase_ctrl: random-walk filtered phase corrections applied to a divide-by-N recovered-clock counter, with lock tracking
module dpll_phase_ctrl #(
  parameter int DIV_N    = 16,
  parameter int LOCK_CNT = 8
) (
  input logic              clk_high,
  input logic              rst,
  dpll_phase_ctrl_if.slave pif
);
  localparam int PW = $clog2(DIV_N);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} st_t;
  st_t st, st_nx;
  logic [2:0] sa, sb;
  logic ev_a, ev_b;
  logic signed [4:0] fc, fc_nx;
  logic signed [5:0] fc_sum, step_v, k_s;
  logic [3:0] k_reg, k_eff, k_cur, lc, lc_nx;
  logic req_a, req_r, req;
  logic [PW-1:0] pc, pc_nx;
  logic at_sp, wrap, apply, adv_now, ret_now;
  logic dir, dir_nx, pend, pend_nx, ovf_set;
  logic corr, last_dir, last_vld, rec_clk_r, locked_r, ovf_r;
  assign k_eff  = (pif.k_sel == '0) ? 4'd1 : pif.k_sel;
  assign k_cur  = (fc == '0) ? k_eff : k_reg;
  assign k_s    = {2'b00, k_cur};
  assign step_v = (ev_a & ~ev_b) ? 6'sd1 : (ev_b & ~ev_a) ? -6'sd1 : 6'sd0;
  assign fc_sum = {fc[4], fc} + step_v;
  assign req_a  = fc_sum == k_s;
  assign req_r  = fc_sum == -k_s;
  assign req    = req_a | req_r;
  assign fc_nx  = req ? 5'sd0 : fc_sum[4:0];
  assign at_sp   = pc == PW'(DIV_N / 4);
  assign wrap    = pc == PW'(DIV_N - 1);
  assign apply   = (st == WAIT) && at_sp;
  assign adv_now = apply & dir;
  assign ret_now = apply & ~dir;
  assign pc_nx   = ret_now ? pc : pc + (adv_now ? PW'(2) : PW'(1));
  assign lc_nx   = apply ? 4'd0 : (wrap && !corr && lc != 4'(LOCK_CNT)) ? lc + 4'd1 : lc;
  // A request landing in HOLD (or on the SP cycle itself) is parked in pend and re-armed at the wrap
  always_comb begin
    st_nx   = st;
    dir_nx  = dir;
    pend_nx = pend;
    ovf_set = 1'b0;
    case (st)
      IDLE: if (req) begin
        st_nx  = WAIT;
        dir_nx = req_a;
      end
      WAIT: if (at_sp) begin
        st_nx   = HOLD;
        pend_nx = req;
        dir_nx  = req ? req_a : dir;
      end else if (req) begin
        if (req_a == dir) ovf_set = 1'b1;
        else st_nx = IDLE;
      end
      HOLD: begin
        if (req) begin
          if (!pend) begin
            pend_nx = 1'b1;
            dir_nx  = req_a;
          end else if (req_a == dir) ovf_set = 1'b1;
          else pend_nx = 1'b0;
        end
        if (wrap) begin
          st_nx   = pend_nx ? WAIT : IDLE;
          pend_nx = 1'b0;
        end
      end
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_high or negedge rst) begin
    if (!rst) begin
      sa        <= '0;
      sb        <= '0;
      ev_a      <= 1'b0;
      ev_b      <= 1'b0;
      fc        <= '0;
      k_reg     <= 4'd1;
      pc        <= '0;
      rec_clk_r <= 1'b1;
      st        <= IDLE;
      dir       <= 1'b0;
      pend      <= 1'b0;
      ovf_r     <= 1'b0;
      lc        <= '0;
      corr      <= 1'b0;
      locked_r  <= 1'b0;
      last_dir  <= 1'b0;
      last_vld  <= 1'b0;
    end else begin
      sa        <= {sa[1:0], pif.ahead_in};
      sb        <= {sb[1:0], pif.behind_in};
      ev_a      <= sa[1] & ~sa[2];
      ev_b      <= sb[1] & ~sb[2];
      fc        <= fc_nx;
      k_reg     <= (fc == '0) ? k_eff : k_reg;
      pc        <= pc_nx;
      rec_clk_r <= pc_nx < PW'(DIV_N / 2);
      st        <= st_nx;
      dir       <= dir_nx;
      pend      <= pend_nx;
      ovf_r     <= ovf_r | ovf_set;
      lc        <= lc_nx;
      corr      <= apply ? 1'b1 : wrap ? 1'b0 : corr;
      locked_r  <= (apply && last_vld && last_dir == dir) ? 1'b0 : (lc_nx == 4'(LOCK_CNT)) ? 1'b1 : locked_r;
      last_dir  <= apply ? dir : last_dir;
      last_vld  <= last_vld | apply;
    end
  end
  assign pif.rec_clk = rec_clk_r;
  assign pif.adj_adv = adv_now;
  assign pif.adj_ret = ret_now;
  assign pif.busy    = st != IDLE;
  assign pif.locked  = locked_r;
  assign pif.ovf     = ovf_r;
endmodule

// File: tb/tb_dpll_phase_ctrl.sv
// tb_dpll_phase_ctrl: directed-vector bench for the DPLL phase controller
module tb_dpll_phase_ctrl;
  logic clk_high = 1'b0;
  logic rst = 1'b0;
  int checks = 0, errors = 0;
  int n_adv = 0, n_ret = 0, busy_cnt = 0, pc_at = -1, pc_after = -1, per_after = -1, per_last = -1;
  int since_rise = 0, hi_run = 0, hi_last = -1, a0, r0, b0;
  bit strobe_d = 1'b0, await_per = 1'b0, rec_d = 1'b1;
  dpll_phase_ctrl_if ifc();
  dpll_phase_ctrl #(.DIV_N(16), .LOCK_CNT(8)) dut (.clk_high(clk_high), .rst(rst), .pif(ifc.slave));
  always #5 clk_high = ~clk_high;
  always @(negedge clk_high) begin
    if (strobe_d) pc_after = int'(dut.pc);
    strobe_d = ifc.adj_adv | ifc.adj_ret;
    if (ifc.adj_adv) n_adv++;
    if (ifc.adj_ret) n_ret++;
    if (strobe_d) begin
      pc_at = int'(dut.pc);
      await_per = 1'b1;
    end
    if (ifc.busy) busy_cnt++;
    since_rise++;
    if (ifc.rec_clk && !rec_d) begin
      per_last = since_rise;
      if (await_per) per_after = since_rise;
      await_per = 1'b0;
      since_rise = 0;
    end
    if (ifc.rec_clk) hi_run++;
    else if (rec_d) begin
      hi_last = hi_run;
      hi_run = 0;
    end
    rec_d = ifc.rec_clk;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk_high);
    #1;
  endtask
  task automatic pulse(input logic a, input logic b);
    ifc.ahead_in = a;
    ifc.behind_in = b;
    step(1);
    ifc.ahead_in = 1'b0;
    ifc.behind_in = 1'b0;
  endtask
  task automatic mark();
    a0 = n_adv;
    r0 = n_ret;
    b0 = busy_cnt;
  endtask
  task automatic align();
    int n = 0;
    while (ifc.rec_clk && n < 40) begin
      step(1);
      n++;
    end
    while (!ifc.rec_clk && n < 40) begin
      step(1);
      n++;
    end
    chk("align_pc", int'(dut.pc), 0);
  endtask
  task automatic apply_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask
  initial begin
    ifc.ahead_in = 1'b0;
    ifc.behind_in = 1'b0;
    ifc.k_sel = 4'd4;
    step(3);
    chk("rst_rec_clk", ifc.rec_clk, 1);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_locked", ifc.locked, 0);
    chk("rst_ovf", ifc.ovf, 0);
    chk("rst_adj", ifc.adj_adv | ifc.adj_ret, 0);
    chk("rst_pc", int'(dut.pc), 0);
    chk("rst_fc", int'(dut.fc), 0);
    // free run
    mark();
    rst = 1'b1;
    step(127);
    chk("lock_before_8th_wrap", ifc.locked, 0);
    step(1);
    chk("lock_at_8th_wrap", ifc.locked, 1);
    step(72);
    chk("free_period", per_last, 16);
    chk("free_high", hi_last, 8);
    chk("free_busy", busy_cnt - b0, 0);
    // advance path, K=4
    mark();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      step(19);
    end
    chk("adv_fc3", int'(dut.fc), 3);
    chk("adv_none_yet", n_adv - a0, 0);
    pulse(1'b1, 1'b0);
    step(40);
    chk("adv_count", n_adv - a0, 1);
    chk("adv_ret_count", n_ret - r0, 0);
    chk("adv_pc_at", pc_at, 4);
    chk("adv_pc_after", pc_after, 6);
    chk("adv_period", per_after, 15);
    chk("adv_fc0", int'(dut.fc), 0);
    // retard path, K=2
    ifc.k_sel = 4'd2;
    mark();
    pulse(1'b0, 1'b1);
    step(10);
    pulse(1'b0, 1'b1);
    step(40);
    chk("ret_count", n_ret - r0, 1);
    chk("ret_adv_count", n_adv - a0, 0);
    chk("ret_pc_at", pc_at, 4);
    chk("ret_pc_after", pc_after, 4);
    chk("ret_period", per_after, 17);
    // K=0 behaves as K=1
    ifc.k_sel = 4'd0;
    mark();
    pulse(1'b1, 1'b0);
    step(40);
    chk("k0_adv_count", n_adv - a0, 1);
    // cancellation
    ifc.k_sel = 4'd1;
    align();
    mark();
    step(5);
    pulse(1'b1, 1'b0);
    step(2);
    pulse(1'b0, 1'b1);
    chk("cancel_busy_wait", ifc.busy, 1);
    step(3);
    chk("cancel_busy_idle", ifc.busy, 0);
    step(30);
    chk("cancel_strobes", (n_adv - a0) + (n_ret - r0), 0);
    chk("cancel_ovf", ifc.ovf, 0);
    // simultaneous events
    ifc.k_sel = 4'd2;
    mark();
    for (int i = 0; i < 10; i++) begin
      pulse(1'b1, 1'b1);
      step(4);
    end
    step(20);
    chk("simul_fc", int'(dut.fc), 0);
    chk("simul_strobes", (n_adv - a0) + (n_ret - r0), 0);
    chk("simul_busy", busy_cnt - b0, 0);
    // same-direction overflow and lock loss
    ifc.k_sel = 4'd1;
    apply_reset();
    step(130);
    chk("ovf_pre_lock", ifc.locked, 1);
    chk("ovf_pre_ovf", ifc.ovf, 0);
    align();
    mark();
    step(5);
    pulse(1'b1, 1'b0);
    step(5);
    pulse(1'b1, 1'b0);
    step(4);
    chk("ovf_set", ifc.ovf, 1);
    chk("ovf_busy", ifc.busy, 1);
    step(6);
    chk("ovf_first_adv", n_adv - a0, 1);
    chk("ovf_lock_kept", ifc.locked, 1);
    step(5);
    pulse(1'b1, 1'b0);
    step(22);
    chk("ovf_second_adv", n_adv - a0, 2);
    chk("ovf_lock_lost", ifc.locked, 0);
    // reset mid-operation
    align();
    step(5);
    pulse(1'b1, 1'b0);
    step(3);
    chk("mid_busy", ifc.busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_rec_clk", ifc.rec_clk, 1);
    chk("mid_rst_adj", ifc.adj_adv | ifc.adj_ret, 0);
    chk("mid_rst_ovf", ifc.ovf, 0);
    chk("mid_rst_pc", int'(dut.pc), 0);
    step(2);
    rst = 1'b1;
    mark();
    step(40);
    chk("mid_after_strobes", (n_adv - a0) + (n_ret - r0), 0);
    chk("mid_after_busy", busy_cnt - b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
